// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned DEF_LINES = 64;
    localparam int unsigned DEF_WORDS = 4;
    localparam int unsigned DEF_OFF_W = $clog2(DEF_WORDS);
    localparam int unsigned DEF_IDX_W = $clog2(DEF_LINES);
    localparam int unsigned DEF_TAG_W = 30 - DEF_OFF_W - DEF_IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        DONE
    } state_t;

    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [31:0] offset_of(input logic [31:0] addr,
                                              input int unsigned off_w);
        return addr_field(addr, 2, off_w);
    endfunction

    function automatic logic [31:0] index_of(input logic [31:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
        return addr_field(addr, 2 + off_w, idx_w);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr,
                                           input int unsigned off_w,
                                           input int unsigned idx_w);
        return addr_field(addr, 2 + off_w + idx_w, 30 - off_w - idx_w);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty storage and line data RAM: one combinational read port,
// one synchronous write port. Only valid/dirty are reset.
module dcache_array #(
    parameter int unsigned LINES = 64,
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned OFF_W = 2,
    parameter int unsigned TAG_W = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [TAG_W-1:0]       rd_tag,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [WORDS*32-1:0]    rd_line,
    input  logic                   data_we,
    input  logic                   meta_we,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [OFF_W-1:0]       wr_off,
    input  logic [31:0]            wr_data,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   wr_dirty
);

    logic [TAG_W-1:0]    tags  [LINES];
    logic [WORDS*32-1:0] data  [LINES];
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;

    // Combinational read of the addressed line and its metadata.
    always_comb begin
        rd_tag   = tags[rd_idx];
        rd_valid = valid[rd_idx];
        rd_dirty = dirty[rd_idx];
        rd_line  = data[rd_idx];
    end

    // Valid/dirty state, cleared asynchronously to invalidate the whole cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (meta_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data storage, not reset.
    always_ff @(posedge clk) begin
        if (meta_we)
            tags[wr_idx] <= wr_tag;
        if (data_we)
            data[wr_idx][{wr_off, 5'b0} +: 32] <= wr_data;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        D_cache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

    state_t             state, state_n;
    logic [OFF_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [TAG_W-1:0]   miss_tag, miss_tag_n;
    logic [IDX_W-1:0]   miss_idx, miss_idx_n;
    logic               mem_req_n, mem_we_n;
    logic [31:0]        mem_addr_n, mem_wdata_n;

    logic [OFF_W-1:0]   cpu_off;
    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;

    logic [IDX_W-1:0]   rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid, rd_dirty;
    logic [WORDS*32-1:0] rd_line;

    logic               data_we, meta_we, wr_dirty;
    logic [IDX_W-1:0]   wr_idx;
    logic [OFF_W-1:0]   wr_off;
    logic [31:0]        wr_data;
    logic [TAG_W-1:0]   wr_tag;

    logic hit, ack, last;

    assign cpu_off = OFF_W'(offset_of(cpu_addr, OFF_W));
    assign cpu_idx = IDX_W'(index_of(cpu_addr, OFF_W, IDX_W));
    assign cpu_tag = TAG_W'(tag_of(cpu_addr, OFF_W, IDX_W));

    // Outside IDLE the array is read at the latched miss line (victim / fill).
    assign rd_idx  = (state == IDLE) ? cpu_idx : miss_idx;
    assign hit     = cpu_valid && rd_valid && (rd_tag == cpu_tag) && (state == IDLE);
    assign ack     = mem_ack && mem_req;
    assign cnt_inc = cnt + 1'b1;
    assign last    = (cnt == OFF_W'(WORDS - 1));

    assign D_cache_stall = !rst && ((state != IDLE) || (cpu_valid && !hit));

    dcache_array #(
        .LINES(LINES),
        .WORDS(WORDS),
        .IDX_W(IDX_W),
        .OFF_W(OFF_W),
        .TAG_W(TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .data_we  (data_we),
        .meta_we  (meta_we),
        .wr_idx   (wr_idx),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .wr_tag   (wr_tag),
        .wr_dirty (wr_dirty)
    );

    // Next-state, next memory-port values, array writes and load data.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        miss_tag_n  = miss_tag;
        miss_idx_n  = miss_idx;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        data_we     = 1'b0;
        meta_we     = 1'b0;
        wr_idx      = cpu_idx;
        wr_off      = cpu_off;
        wr_data     = cpu_wdata;
        wr_tag      = cpu_tag;
        wr_dirty    = 1'b0;
        cpu_rdata   = '0;

        case (state)
            IDLE: begin
                if (hit) begin
                    if (cpu_we) begin
                        data_we  = 1'b1;
                        meta_we  = 1'b1;
                        wr_dirty = 1'b1;
                    end else begin
                        cpu_rdata = rd_line[{cpu_off, 5'b0} +: 32];
                    end
                end else if (cpu_valid) begin
                    miss_tag_n = cpu_tag;
                    miss_idx_n = cpu_idx;
                    cnt_n      = '0;
                    mem_req_n  = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_n     = WB;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = {rd_tag, cpu_idx, {OFF_W{1'b0}}, 2'b00};
                        mem_wdata_n = rd_line[31:0];
                    end else begin
                        state_n    = REFILL;
                        mem_we_n   = 1'b0;
                        mem_addr_n = {cpu_tag, cpu_idx, {OFF_W{1'b0}}, 2'b00};
                    end
                end
            end
            WB: begin
                if (ack) begin
                    if (last) begin
                        cnt_n      = '0;
                        state_n    = REFILL;
                        mem_we_n   = 1'b0;
                        mem_addr_n = {miss_tag, miss_idx, {OFF_W{1'b0}}, 2'b00};
                    end else begin
                        cnt_n       = cnt_inc;
                        mem_addr_n  = {rd_tag, miss_idx, cnt_inc, 2'b00};
                        mem_wdata_n = rd_line[{cnt_inc, 5'b0} +: 32];
                    end
                end
            end
            REFILL: begin
                if (ack) begin
                    data_we = 1'b1;
                    wr_idx  = miss_idx;
                    wr_off  = cnt;
                    wr_data = mem_rdata;
                    if (last) begin
                        meta_we   = 1'b1;
                        wr_tag    = miss_tag;
                        wr_dirty  = 1'b0;
                        cnt_n     = '0;
                        mem_req_n = 1'b0;
                        state_n   = DONE;
                    end else begin
                        cnt_n      = cnt_inc;
                        mem_addr_n = {miss_tag, miss_idx, cnt_inc, 2'b00};
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM, word counter, latched miss address and registered memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            miss_tag  <= '0;
            miss_idx  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            miss_tag  <= miss_tag_n;
            miss_idx  <= miss_idx_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: architectural memory reference plus
// a tag-level cache model predict load data, stalls and memory traffic.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        D_cache_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(64), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .D_cache_stall(D_cache_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] rq[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] backing [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          lat_fixed = 2;
    bit          spurious  = 0;

    bit          mv [64];
    bit          md [64];
    int unsigned mt [64];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] back_rd(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: per-word wait states then a one-cycle ack.
    initial begin
        int wait_left;
        wait_left = -1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (wait_left < 0)
                    wait_left = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) backing[mem_addr] = mem_wdata;
                    else        mem_rdata = back_rd(mem_addr);
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = -1;
                if (spurious && $urandom_range(0, 3) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: transfer stability, transfer order/content, load data.
    initial begin
        logic        held;
        logic        hwe;
        logic [31:0] ha, hd;
        xfer_t       x;
        logic [31:0] e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (mem_req) begin
                    if (held) begin
                        chk("hold_we", {31'b0, mem_we}, {31'b0, hwe});
                        chk("hold_addr", mem_addr, ha);
                        if (hwe) chk("hold_wdata", mem_wdata, hd);
                    end else begin
                        held = 1'b1;
                        hwe  = mem_we;
                        ha   = mem_addr;
                        hd   = mem_wdata;
                    end
                    if (mem_ack) begin
                        if (xq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL xfer_extra: got addr %h we %0d want none", mem_addr, mem_we);
                        end else begin
                            x = xq.pop_front();
                            chk("xfer_we", {31'b0, mem_we}, {31'b0, x.we});
                            chk("xfer_addr", mem_addr, x.addr);
                            if (x.we) chk("xfer_wdata", mem_wdata, x.data);
                        end
                        held = 1'b0;
                    end
                end else begin
                    held = 1'b0;
                end
                if (cpu_valid) begin
                    if (D_cache_stall) begin
                        chk("rdata_zero", cpu_rdata, 32'h0);
                    end else if (!cpu_we) begin
                        if (rq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL load_extra: got %h want none", cpu_rdata);
                        end else begin
                            e = rq.pop_front();
                            chk("load_data", cpu_rdata, e);
                        end
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
    endtask

    // One pipeline access: predict, push expectations, drive, wait for completion.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, output int stalls);
        int unsigned idx, tag;
        bit          miss, done;
        xfer_t       x;
        logic [31:0] a;
        idx  = (addr >> 4) % 64;
        tag  = addr >> 10;
        a    = addr & ~32'h3;
        miss = !(mv[idx] && mt[idx] == tag);
        if (miss) begin
            if (mv[idx] && md[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    x.we   = 1'b1;
                    x.addr = (mt[idx] << 10) | (idx << 4) | (w << 2);
                    x.data = ref_rd(x.addr);
                    xq.push_back(x);
                end
            end
            for (int w = 0; w < 4; w++) begin
                x.we   = 1'b0;
                x.addr = (addr & ~32'hF) | (w << 2);
                x.data = '0;
                xq.push_back(x);
            end
            mv[idx] = 1;
            mt[idx] = tag;
            md[idx] = 0;
        end
        if (we) begin
            ref_mem[a] = wd;
            md[idx]    = 1;
        end else begin
            rq.push_back(ref_rd(a));
        end
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        stalls    = 0;
        done      = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("first_stall", {31'b0, D_cache_stall}, {31'b0, miss});
                if (!miss) chk("hit_no_req", {31'b0, mem_req}, 32'h0);
            end
            if (D_cache_stall) stalls++;
            else done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL access_timeout: addr %h still stalled, want completion", addr);
        end
        cpu_valid = 1'b0;
        chk("xfers_consumed", xq.size(), 32'h0);
    endtask

    initial begin
        int    s;
        int    found;
        xfer_t x;
        logic  rw;
        logic [31:0] ra;

        rst = 1'b1;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'b0, D_cache_stall}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;

        for (int w = 0; w < 4; w++) begin
            backing[32'h100 + w * 4] = 32'h11 * (w + 1);
            ref_mem[32'h100 + w * 4] = 32'h11 * (w + 1);
        end

        lat_fixed = 2;
        do_access(1'b0, 32'h100, 32'h0, s);          chk("cold_miss_stall", s, 14);
        do_access(1'b0, 32'h104, 32'h0, s);          chk("load_hit_stall", s, 0);
        do_access(1'b1, 32'h104, 32'hDEADBEEF, s);   chk("store_hit_stall", s, 0);
        do_access(1'b0, 32'h104, 32'h0, s);          chk("reload_hit_stall", s, 0);
        do_access(1'b0, 32'h500, 32'h0, s);          chk("dirty_miss_stall", s, 26);
        chk("wb_word1", back_rd(32'h104), 32'hDEADBEEF);
        do_access(1'b1, 32'h2008, 32'hCAFE0000, s);  chk("store_miss_stall", s, 14);
        do_access(1'b0, 32'h3008, 32'h0, s);         chk("evict_store_stall", s, 26);
        chk("evict_data", back_rd(32'h2008), 32'hCAFE0000);

        // Reset during the second refill word of a clean miss.
        x.we = 1'b0; x.addr = 32'h7040; x.data = '0;
        xq.push_back(x);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7040; cpu_wdata = '0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h7044) found = 1;
        end
        chk("reach_word1", found, 1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("midrst_stall", {31'b0, D_cache_stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_valid = 1'b0;
        xq.delete();
        rq.delete();
        ref_mem = backing;
        model_reset();
        do_access(1'b0, 32'h7040, 32'h0, s);         chk("post_rst_stall", s, 14);
        do_access(1'b0, 32'h104, 32'h0, s);          chk("post_rst_invalid", s, 14);

        // Randomized conflicts, random wait states, stray acks while idle.
        lat_fixed = -1;
        spurious  = 1;
        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            do_access(rw, ra, $urandom, s);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        spurious = 0;
        repeat (4) @(posedge clk);
        chk("queues_empty", xq.size() + rq.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache sitting between the pipeline's MEM stage and the word-wide main-memory port. It answers the pipeline's load/store requests, which are address, write data, write enable and access-valid, all driven from EX/MEM. Hits complete in the same cycle. On a miss it asserts `D_cache_stall`, writes back a dirty victim line, refills the line word by word over a req/ack handshake, then completes the access.

## Interface
Parameters:
- `LINES`, 64: number of cache lines; power of 2.
- `WORDS`, 4: 32-bit words per line; power of 2.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_valid` in 1: memory access request from EX/MEM.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address, word-aligned; bits [1:0] ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data, captured by MEM/WB.
- `D_cache_stall` out 1: freezes the whole pipeline while high.
- `mem_req` out 1: memory transfer request.
- `mem_we` out 1: 1 = write-back word, 0 = refill read.
- `mem_addr` out 32: word address of the current transfer, byte-addressed.
- `mem_wdata` out 32: write-back data.
- `mem_rdata` in 32: refill data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle pulse that completes the current transfer.

## Operation
- Address split: offset = `cpu_addr[2 +: log2(WORDS)]`, index = next `log2(LINES)` bits, tag = remaining upper bits.
- Hit is combinational: `cpu_valid` && valid[index] && tag match && state == IDLE.
- FSM states: IDLE, WB, REFILL, DONE.
- IDLE, load hit: `cpu_rdata` = array word, combinational, same cycle. No stall.
- IDLE, store hit: the word is written at the clock edge and dirty[index] is set. No stall.
- IDLE, miss: `D_cache_stall` rises combinationally in the same cycle. The miss index and tag are latched.
  - Victim valid and dirty: go to WB.
  - Otherwise: go to REFILL.
  - The word counter clears.
- WB: `mem_req`=1, `mem_we`=1, `mem_addr` = {victim tag, index, cnt, 2'b00}, `mem_wdata` = line[cnt].
  - Each `mem_ack` increments cnt.
  - After the ack for word WORDS-1, cnt clears and the FSM goes to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr` = {miss tag, index, cnt, 2'b00}.
  - Each `mem_ack` writes `mem_rdata` into line[cnt].
  - After the last ack, the tag is installed, valid=1, dirty=0, and the FSM goes to DONE.
- DONE: one cycle with stall still high, then IDLE. In IDLE the retried access hits: loads return data, stores write and set dirty, and the stall drops.
- `cpu_*` inputs are held stable by the pipeline while stall is high. The controller still uses the latched miss address for all memory traffic.
- If `cpu_valid` is low in DONE/IDLE after a fill, the line stays installed and nothing is written.
- `mem_ack` while `mem_req`=0 is ignored.
- `cpu_rdata` = 0 when there is no load hit.

## Timing
- Reset values:
  - state IDLE, cnt 0, all valid and dirty bits 0.
  - `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - `D_cache_stall` = 0 when `cpu_valid`=0. The data array is not reset.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They are stable from the first cycle of a transfer until the cycle of its `mem_ack`.
  - The next word is presented the cycle after the ack; back-to-back acks are legal.
  - Wait states are unbounded.
- Clean miss with ack latency L cycles per word: stall high for 1 + WORDS·(L+1) + 1 cycles.
- Dirty miss: twice the transfer term.
- `rst` mid-operation takes effect immediately and asynchronously:
  - `mem_req` drops, FSM returns to IDLE, all lines are invalidated.
  - In-flight write-back data is lost.
- Hit store and miss detection never coincide (hit and miss are mutually exclusive by definition).

## Structure
- Shared package `dcache_pkg`:
  - FSM state enum (IDLE/WB/REFILL/DONE).
  - Field-width localparams derived from `LINES`/`WORDS`.
  - tag/index/offset extract functions.
- Sub-module `dcache_array`: tag, valid and dirty storage plus the data RAM.
  - One combinational read port, one synchronous write port.
  - Valid/dirty bits reset asynchronously.
- The controller FSM, counter and muxing live in `dcache_ctrl`.

## Test plan
- Cold read miss at 0x100 after reset, memory returns 0x11,0x22,0x33,0x44 with L=2:
  - Stall is held for 1+4·3+1 = 14 cycles and reads go to 0x100, 0x104, 0x108, 0x10C.
  - `cpu_rdata`=0x11. A following load of 0x104 returns 0x22 with no stall.
- Store hit at 0x104 with 0xDEADBEEF: no `mem_req`, no stall; a following load returns 0xDEADBEEF.
- Load of 0x500 (same index, default params) after that store:
  - Write-back of 0x100..0x10C carries 0x11, 0xDEADBEEF, 0x33, 0x44.
  - Refill from 0x500..0x50C follows. No duplicate or skipped words.
- Store miss to 0x2008 with 0xCAFE0000:
  - Refill occurs, then the store writes word 2 and sets dirty.
  - Evicting that line later writes 0xCAFE0000 to 0x2008.
- Random `mem_ack` delays of 0–5 cycles, including back-to-back acks:
  - `mem_addr`, `mem_we` and `mem_wdata` never change before an ack.
  - Exactly WORDS acks are consumed per phase.
- `rst` pulsed during the 2nd refill word:
  - `mem_req` goes 0 in the same cycle and stall drops.
  - Re-access of the same address misses and refills from word 0.
